// File: rtl/fetch_pc.sv
// Sequential Y86-64 fetch stage: byte-addressed instruction memory, instruction
// split into icode/ifun/rA/rB/valC/valP, PC register and a terminal status FSM.
module fetch_pc #(
    parameter int            n          = 64,
    parameter int            IMEM_BYTES = 1024,
    parameter logic [n-1:0]  RESET_PC   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cnd,
    input  logic [n-1:0] valM,
    input  logic         dmem_error,
    input  logic         imem_we,
    input  logic [n-1:0] imem_waddr,
    input  logic [7:0]   imem_wdata,
    output logic [n-1:0] pc,
    output logic [3:0]   icode,
    output logic [3:0]   ifun,
    output logic [3:0]   rA,
    output logic [3:0]   rB,
    output logic [n-1:0] valC,
    output logic [n-1:0] valP,
    output logic [1:0]   stat,
    output logic         instr_valid,
    output logic [1:0]   dbg_state_o
);

    localparam int          AW         = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [n:0]  IMEM_LIMIT = (n+1)'(IMEM_BYTES);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_HALTED  = 2'd1;
    localparam logic [1:0] S_ERR_ADR = 2'd2;
    localparam logic [1:0] S_ERR_INS = 2'd3;

    logic [7:0]   mem_q [IMEM_BYTES];
    logic [n-1:0] pc_q, pc_d;
    logic [1:0]   state_q, state_d;

    logic [7:0]   fbyte [10];
    logic [n-1:0] byte_addr;
    logic [3:0]   ilen;
    logic         has_reg;
    logic         ifun_ok;
    logic         imem_error;
    logic [1:0]   fetch_stat;
    logic [n-1:0] next_pc;

    // Program load port; deliberately outside the reset so loads during reset stick.
    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < IMEM_LIMIT)) begin
            mem_q[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // Bytes past the end of memory read as zero; such fetches are flagged ADR anyway.
    always_comb begin
        byte_addr = '0;
        for (int k = 0; k < 10; k++) begin
            byte_addr = pc_q + n'(k);
            if ({1'b0, byte_addr} < IMEM_LIMIT) begin
                fbyte[k] = mem_q[byte_addr[AW-1:0]];
            end else begin
                fbyte[k] = 8'h00;
            end
        end
    end

    always_comb begin
        icode   = fbyte[0][7:4];
        ifun    = fbyte[0][3:0];
        ilen    = 4'd1;
        has_reg = 1'b0;
        ifun_ok = (ifun == 4'h0);
        valC    = '0;
        case (icode)
            4'h0, 4'h1, 4'h9: ilen = 4'd1;
            4'h2: begin ilen = 4'd2; has_reg = 1'b1; ifun_ok = (ifun <= 4'h6); end
            4'h6: begin ilen = 4'd2; has_reg = 1'b1; ifun_ok = (ifun <= 4'h3); end
            4'hA, 4'hB: begin ilen = 4'd2; has_reg = 1'b1; end
            4'h7: begin
                ilen    = 4'd9;
                ifun_ok = (ifun <= 4'h6);
                valC    = n'({fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                              fbyte[4], fbyte[3], fbyte[2], fbyte[1]});
            end
            4'h8: begin
                ilen = 4'd9;
                valC = n'({fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                           fbyte[4], fbyte[3], fbyte[2], fbyte[1]});
            end
            4'h3, 4'h4, 4'h5: begin
                ilen    = 4'd10;
                has_reg = 1'b1;
                valC    = n'({fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                              fbyte[5], fbyte[4], fbyte[3], fbyte[2]});
            end
            default: begin ilen = 4'd1; ifun_ok = 1'b0; end
        endcase
        rA   = has_reg ? fbyte[1][7:4] : 4'hF;
        rB   = has_reg ? fbyte[1][3:0] : 4'hF;
        valP = pc_q + n'(ilen);
    end

    // Last byte is computed one bit wider so a PC near 2^n cannot wrap past the check.
    always_comb begin
        imem_error = ({1'b0, pc_q} >= IMEM_LIMIT) ||
                     (({1'b0, pc_q} + (n+1)'(ilen) - (n+1)'(1)) >= IMEM_LIMIT);
        if (imem_error)           fetch_stat = STAT_ADR;
        else if (!ifun_ok)        fetch_stat = STAT_INS;
        else if (icode == 4'h0)   fetch_stat = STAT_HLT;
        else                      fetch_stat = STAT_AOK;
    end

    always_comb begin
        if (icode == 4'h8 || (icode == 4'h7 && cnd)) next_pc = valC;
        else if (icode == 4'h9)                      next_pc = valM;
        else                                         next_pc = valP;
    end

    // Reset forces AOK/not-valid combinationally so a frozen core reports clean at once.
    always_comb begin
        case (state_q)
            S_RUN:     stat = dmem_error ? STAT_ADR : fetch_stat;
            S_HALTED:  stat = STAT_HLT;
            S_ERR_ADR: stat = STAT_ADR;
            default:   stat = STAT_INS;
        endcase
        if (!rst_n) stat = STAT_AOK;
        instr_valid = rst_n && (state_q == S_RUN) && (stat == STAT_AOK);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == S_RUN) begin
            case (stat)
                STAT_AOK: pc_d    = next_pc;
                STAT_HLT: state_d = S_HALTED;
                STAT_ADR: state_d = S_ERR_ADR;
                default:  state_d = S_ERR_INS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc          = pc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios plus random programs, scored against a
// byte-level model of the Y86-64 fetch rules through an expected-value queue.
module tb_fetch_pc;

    localparam int          N    = 64;
    localparam int          IMEM = 1024;
    localparam logic [63:0] RPC  = 64'd0;

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [1:0]  stat;
        logic        iv;
    } obs_t;
    localparam int W = $bits(obs_t);

    logic         clk, rst_n, cnd, dmem_error, imem_we;
    logic [63:0]  valM, imem_waddr;
    logic [7:0]   imem_wdata;
    logic [63:0]  pc, valC, valP;
    logic [3:0]   icode, ifun, rA, rB;
    logic [1:0]   stat, dbg_state;
    logic         instr_valid;

    fetch_pc #(.n(N), .IMEM_BYTES(IMEM), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .cnd(cnd), .valM(valM), .dmem_error(dmem_error),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .valP(valP), .stat(stat), .instr_valid(instr_valid), .dbg_state_o(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic [7:0]  m_mem [IMEM];
    logic [63:0] m_pc;
    logic        m_frozen;
    logic [1:0]  m_code;
    logic        rel_pending;

    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] mb(input logic [63:0] a);
        return (a < 64'(IMEM)) ? m_mem[a[9:0]] : 8'h00;
    endfunction

    function automatic int ilen(input logic [3:0] ic);
        if (ic == 4'h7 || ic == 4'h8) return 9;
        if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) return 10;
        if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) return 2;
        return 1;
    endfunction

    function automatic logic has_reg(input logic [3:0] ic);
        return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] w = 64'd0;
        for (int i = 0; i < 8; i++) w = w | (64'(mb(a + 64'(i))) << (8 * i));
        return w;
    endfunction

    function automatic obs_t model_obs(input logic [63:0] p, input logic de, input logic in_rst);
        obs_t o;
        logic [7:0] b, r;
        int len;
        logic bad;
        logic [1:0] fst;
        b = mb(p);
        r = mb(p + 64'd1);
        o.pc = p;
        o.icode = b[7:4];
        o.ifun = b[3:0];
        o.ra = has_reg(o.icode) ? r[7:4] : 4'hF;
        o.rb = has_reg(o.icode) ? r[3:0] : 4'hF;
        if (o.icode == 4'h7 || o.icode == 4'h8) o.valc = word_at(p + 64'd1);
        else if (o.icode inside {4'h3, 4'h4, 4'h5}) o.valc = word_at(p + 64'd2);
        else o.valc = 64'd0;
        len = ilen(o.icode);
        o.valp = p + 64'(len);
        if (o.icode >= 4'hC) bad = 1'b1;
        else if (o.icode == 4'h2 || o.icode == 4'h7) bad = (o.ifun > 4'd6);
        else if (o.icode == 4'h6) bad = (o.ifun > 4'd3);
        else bad = (o.ifun != 4'd0);
        if (p >= 64'(IMEM) || (64'(IMEM) - p) < 64'(len)) fst = 2'd2;
        else if (bad) fst = 2'd3;
        else if (o.icode == 4'h0) fst = 2'd1;
        else fst = 2'd0;
        if (in_rst) o.stat = 2'd0;
        else if (m_frozen) o.stat = m_code;
        else o.stat = de ? 2'd2 : fst;
        o.iv = !in_rst && !m_frozen && (o.stat == 2'd0);
        return o;
    endfunction

    function automatic logic [63:0] model_next(input obs_t o, input logic c, input logic [63:0] vm);
        if (o.icode == 4'h8 || (o.icode == 4'h7 && c)) return o.valc;
        if (o.icode == 4'h9) return vm;
        return o.valp;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic put(input logic [63:0] a, input logic [7:0] d);
        @(negedge clk);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        @(posedge clk);
        if (a < 64'(IMEM)) m_mem[a[9:0]] = d;
        #1 imem_we = 1'b0;
    endtask

    task automatic put_word(input logic [63:0] a, input logic [63:0] w);
        for (int i = 0; i < 8; i++) put(a + 64'(i), w[8*i +: 8]);
    endtask

    task automatic begin_load();
        @(negedge clk);
        rst_n = 1'b0;
        m_pc = RPC; m_frozen = 1'b0; rel_pending = 1'b0;
    endtask

    task automatic release_rst();
        rel_pending = 1'b1;
    endtask

    task automatic cycle(input logic c, input logic [63:0] vm, input logic de);
        obs_t o;
        logic [63:0] nxt;
        @(negedge clk);
        if (rel_pending) begin rst_n = 1'b1; rel_pending = 1'b0; end
        cnd = c; valM = vm; dmem_error = de;
        #1;
        o = model_obs(m_pc, de, !rst_n);
        exp_q.push_back(o);
        nxt = model_next(o, c, vm);
        @(posedge clk);
        if (rst_n && !m_frozen) begin
            if (o.stat == 2'd0) m_pc = nxt;
            else begin m_frozen = 1'b1; m_code = o.stat; end
        end
    endtask

    task automatic async_rst_check(input string tag);
        #2;
        rst_n = 1'b0;
        m_pc = RPC; m_frozen = 1'b0;
        #1;
        chk({tag, "_pc"}, pc, RPC);
        chk({tag, "_stat"}, 64'(stat), 64'd0);
        chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    endtask

    task automatic gen_program();
        logic [63:0] a;
        logic [3:0] ic_tab [11];
        logic [3:0] ic, fn, fmax;
        int pick;
        ic_tab = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        a = 64'd0;
        while (a < 64'd100) begin
            pick = $urandom_range(0, 99);
            if (pick < 4) ic = 4'h0;
            else if (pick < 7) ic = 4'($urandom_range(12, 15));
            else ic = ic_tab[$urandom_range(0, 10)];
            fmax = (ic == 4'h2 || ic == 4'h7) ? 4'd6 : (ic == 4'h6) ? 4'd3 : 4'd0;
            fn = 4'($urandom_range(0, int'(fmax)));
            if ($urandom_range(0, 19) == 0) fn = 4'($urandom_range(0, 15));
            put(a, {ic, fn});
            if (has_reg(ic)) put(a + 64'd1, 8'($urandom_range(0, 255)));
            if (ic == 4'h7 || ic == 4'h8) put_word(a + 64'd1, 64'($urandom_range(0, 110)));
            else if (ic inside {4'h3, 4'h4, 4'h5}) put_word(a + 64'd2, {$urandom, $urandom});
            a = a + 64'(ilen(ic));
        end
    endtask

    // Scoreboard monitor: one expected entry per driven cycle, sampled mid-low-phase.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("icode", 64'(icode), 64'(e.icode));
                chk("ifun", 64'(ifun), 64'(e.ifun));
                chk("rA", 64'(rA), 64'(e.ra));
                chk("rB", 64'(rB), 64'(e.rb));
                chk("valC", valC, e.valc);
                chk("valP", valP, e.valp);
                chk("stat", 64'(stat), 64'(e.stat));
                chk("instr_valid", 64'(instr_valid), 64'(e.iv));
            end
        end
    end

    initial begin
        logic [63:0] vm;
        rst_n = 1'b0; cnd = 1'b0; valM = '0; dmem_error = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        m_pc = RPC; m_frozen = 1'b0; m_code = 2'd0; rel_pending = 1'b0;
        for (int i = 0; i < IMEM; i++) m_mem[i] = 8'h00;

        // Clear memory while held in reset, then check the reset view.
        for (int i = 0; i < IMEM; i++) put(64'(i), 8'h00);
        cycle(1'b0, 64'd0, 1'b0);

        // irmovq $10,%rdx then nop; out-of-range write must be dropped.
        begin_load();
        put(0, 8'h30); put(1, 8'hF2); put_word(2, 64'd10); put(10, 8'h10);
        put(64'd1024, 8'hFF);
        release_rst();
        repeat (4) cycle(1'b0, 64'd0, 1'b0);

        // jXX not taken / taken, then illegal ifun.
        begin_load();
        put(0, 8'h73); put_word(1, 64'h20);
        release_rst();
        repeat (2) cycle(1'b0, 64'd0, 1'b0);
        begin_load(); release_rst();
        repeat (2) cycle(1'b1, 64'd0, 1'b0);
        begin_load(); put(0, 8'h77); release_rst();
        repeat (3) cycle(1'b0, 64'd0, 1'b0);

        // call then ret.
        begin_load();
        put(0, 8'h80); put_word(1, 64'h40); put(64'h40, 8'h90); put(9, 8'h10);
        release_rst();
        cycle(1'b0, 64'd0, 1'b0);
        cycle(1'b0, 64'd9, 1'b0);
        cycle(1'b0, 64'd0, 1'b0);

        // halt holds, then asynchronous reset clears status immediately.
        begin_load(); put(0, 8'h00); release_rst();
        repeat (6) cycle(1'b0, 64'd0, 1'b0);
        async_rst_check("halt_rst");

        // INS and ADR cases.
        begin_load(); put(0, 8'hC0); release_rst();
        repeat (2) cycle(1'b0, 64'd0, 1'b0);
        begin_load(); put(0, 8'h65); release_rst();
        repeat (2) cycle(1'b0, 64'd0, 1'b0);
        begin_load();
        put(0, 8'h70); put_word(1, 64'(IMEM - 5));
        put(64'(IMEM - 5), 8'h30); put(64'(IMEM - 4), 8'hF1);
        release_rst();
        repeat (3) cycle(1'b1, 64'd0, 1'b0);
        begin_load(); put(0, 8'h10); release_rst();
        repeat (3) cycle(1'b0, 64'd0, 1'b1);

        // Asynchronous reset between edges while pc=0x40.
        begin_load();
        put(0, 8'h70); put_word(1, 64'h40); put(64'h40, 8'h10);
        release_rst();
        cycle(1'b1, 64'd0, 1'b0);
        async_rst_check("mid_rst");

        // Random programs.
        for (int it = 0; it < 40; it++) begin
            begin_load();
            gen_program();
            release_rst();
            repeat (30) begin
                vm = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 110));
                cycle(1'($urandom_range(0, 1)), vm, ($urandom_range(0, 29) == 0));
            end
        end

        repeat (2) @(negedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Sequential Y86-64 fetch stage with program-counter register. Sits directly upstream of decode_writeback and supplies its icode, rA and rB.
- Holds a byte-addressed instruction memory. Splits the instruction at PC into icode, ifun, rA, rB, valC and valP, and flags status.
- Each posedge clk it commits the next PC, selected from valP, valC or valM.
- A status state machine freezes the processor on halt, an invalid instruction or an address error.

Parameters:
- n, 64, data/address width.
- IMEM_BYTES, 1024, instruction memory size in bytes.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cnd  input  1  branch condition from execute, for jXX.
- valM  input  n  word read from data memory; return address for ret.
- dmem_error  input  1  data-memory address error in the current cycle.
- imem_we  input  1  instruction-memory byte write enable (program load).
- imem_waddr  input  n  instruction-memory byte write address.
- imem_wdata  input  8  instruction-memory byte write data.
- pc  output  n  current PC register.
- icode  output  4  high nibble of byte[pc].
- ifun  output  4  low nibble of byte[pc].
- rA  output  4  register specifier A; 4'hF when the instruction has no register byte.
- rB  output  4  register specifier B; 4'hF when the instruction has no register byte.
- valC  output  n  little-endian constant word.
- valP  output  n  pc + instruction length.
- stat  output  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
- instr_valid  output  1  high when the fetched instruction will execute this cycle.

Behaviour:
- Instruction lengths by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmov, 6 OPq, A pushq, B popq: 2 bytes.
  - 7 jXX, 8 call: 9 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
- Register byte is byte[pc+1]: rA = upper nibble, rB = lower nibble. Present for icode 2,3,4,5,6,A,B.
- valC source:
  - bytes pc+1..pc+8 for icode 7,8;
  - bytes pc+2..pc+9 for icode 3,4,5;
  - 0 otherwise.
  - Little-endian: lowest address is the LSB.
- Fetch decode is combinational from pc and memory; no output latency within a cycle.
- Legal ifun values: 0..6 for icode 2 and 7; 0..3 for icode 6; 0 for all others. icode C..F is illegal.
- Fetch status, in priority order:
  - imem_error if pc + length - 1 >= IMEM_BYTES, or pc >= IMEM_BYTES → ADR;
  - illegal icode/ifun → INS;
  - icode 0 → HLT;
  - otherwise AOK.
- State machine: RUN, HALTED, ERR_ADR, ERR_INS.
  - RUN: stat = fetch status, or ADR if dmem_error. instr_valid = 1 only when stat = AOK.
  - At posedge in RUN:
    - if stat = AOK, pc <= next PC and stay in RUN;
    - if HLT, go to HALTED;
    - if ADR, go to ERR_ADR;
    - if INS, go to ERR_INS.
    - pc holds in every non-AOK case.
  - HALTED / ERR_*: terminal. pc frozen, instr_valid = 0, stat = latched code (HLT/ADR/INS). Decode outputs still reflect byte[pc]. Only reset exits.
- Next PC:
  - icode 8 (call) → valC;
  - icode 7 with cnd = 1 → valC;
  - icode 9 (ret) → valM;
  - otherwise → valP.
  - Addition is modulo 2^n.
- Instruction memory:
  - Write on posedge when imem_we, in any state, including during reset.
  - Writes with imem_waddr >= IMEM_BYTES are ignored.
  - Contents are not cleared by reset and are uninitialised at power-up.
  - A write to a byte being fetched in the same cycle becomes visible only after the edge.
- Reset (rst_n low, asynchronous): pc = RESET_PC, state = RUN, instr_valid = 0, stat = AOK. Decode outputs follow byte[RESET_PC].
- Reset mid-operation abandons the current instruction immediately, from any state.
- First update occurs at the first posedge after rst_n rises.
- pc and state are updated on posedge only. decode_writeback writes on negedge, so consumers see a stable pc for the whole cycle.

Test Plan:
- Load 30 F2 0A 00 00 00 00 00 00 00 at 0 and 10 at 10; release reset → icode=3, rA=F, rB=2, valC=10, valP=10, stat=0. After one posedge: pc=10, icode=1, valP=11.
- Load 73 20 00 00 00 00 00 00 00 at 0.
  - With cnd=0 → pc=9 after edge.
  - Reset, set cnd=1 → pc=0x20.
  - Any ifun 7 (byte 77) → stat=3, then ERR_INS; pc holds at 0.
- Load 80 40 00.. at 0 and 90 at 0x40 → call: valP=9, pc=0x40. Ret with valM=9 → pc=9.
- Load 00 at 0 → stat=1, instr_valid=0; pc stays 0 for 5 edges. Pull rst_n low → stat=0 immediately, pc=0.
- Illegal/ADR cases:
  - Byte C0 → INS.
  - Byte 65 → INS.
  - irmovq at pc=IMEM_BYTES-5 → ADR.
  - dmem_error=1 on a nop → ADR, and pc frozen.
- Async reset asserted between edges while pc=0x40 → pc=RESET_PC without a clock edge. Writes with imem_we during reset land in memory.
